switch_xbar: RTL and testbench
==============================

Name: switch_xbar

Overview:
Parametrised N-port packet-word crossbar. It is the successor to the fixed 4-port switch. Each input port presents a word with a destination address under a valid/ack handshake. Each output port owns a FIFO that is fed through a per-output round-robin arbiter and drained by a valid/ack consumer. Words with out-of-range addresses are dropped and counted. The block sits between the X-side devices and the Y-side consumers.

Parameters:
NPORT, 4, number of input ports and number of output ports (2..16)
DW, 4, data word width
DEPTH, 2, log2 of entries per output FIFO (4 entries)
AW, 3, address field width per input; must satisfy 2^AW >= NPORT
CW, 8, width of the drop counter

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  synchronous reset, active high
in_valid  in  NPORT  per-input word valid
in_adr  in  NPORT*AW  per-input destination; port i uses bits [i*AW +: AW]
in_dat  in  NPORT*DW  per-input data; port i uses bits [i*DW +: DW]
in_ack  out  NPORT  per-input accept, combinational, same cycle as accept
out_valid  out  NPORT  output FIFO j is non-empty
out_dat  out  NPORT*DW  head word of output FIFO j
out_ack  in  NPORT  consumer pop for output j
out_cnt  out  NPORT*(DEPTH+1)  fill level of output FIFO j
drop_cnt  out  CW  count of dropped (bad-address) words, saturating

Behaviour:
- Reset: rst_i is sampled on clk_i. All FIFOs are flushed and all counts and pointers are cleared. Values during and after reset:
  - out_valid = 0, out_dat = 0, out_cnt = 0, drop_cnt = 0, every rr_j = 0.
  - in_ack is forced to 0 while rst_i = 1.
  - Reset mid-transfer discards all stored words, with no partial delivery.
- Input handshake:
  - A word transfers on a rising edge where in_valid[i] = 1 and in_ack[i] = 1.
  - The source holds in_adr/in_dat stable while in_valid = 1 and in_ack = 0.
  - The source may present a new word in the cycle after ack, giving 1 word/cycle/input.
- Address decode: destination j = in_adr[i]. If in_adr[i] >= NPORT the address is bad:
  - in_ack[i] = 1 in that cycle unconditionally; the word is discarded.
  - drop_cnt += number of bad-address accepts that cycle, saturating at 2^CW-1.
- Arbitration, per output j, each cycle:
  - req_j[i] = in_valid[i] & (in_adr[i]==j) & ~full_j.
  - full_j is the registered FIFO state (count == 2^DEPTH). A pop in the same cycle does NOT free space for a same-cycle push.
  - Grant goes to the first requester scanning i = rr_j, rr_j+1, ..., wrapping modulo NPORT.
  - On grant to i: in_ack[i] = 1, the word is pushed at the edge, and rr_j <= (i+1) mod NPORT.
  - With no grant, rr_j holds.
  - Each input targets one output, so each input gets at most one grant per cycle; different outputs accept in parallel.
- Output FIFO j (2^DEPTH entries, show-ahead):
  - out_valid[j] = (count_j != 0); out_dat is the head word; out_dat = 0 when empty.
  - Pop on an edge where out_valid[j] & out_ack[j]. out_ack while empty is ignored.
  - Simultaneous push and pop with 0 < count < full: count is unchanged; both the write and read pointers advance.
  - Push into an empty FIFO: the word is visible on out_dat/out_valid in the next cycle (1-cycle latency input to output).
  - Pointers are DEPTH bits and wrap naturally; count is DEPTH+1 bits.
  - A full FIFO back-pressures: in_ack stays 0 for requesters to that output; no overflow.
- Ordering: words from one input to one output stay in order. Interleaving across inputs follows round-robin order.
- No combinational path from out_ack to in_ack.

Test Plan:
- Reset and idle: hold rst_i = 1 for 3 cycles with in_valid = 4'hF -> in_ack = 0, out_valid = 0, out_cnt = 0, drop_cnt = 0. After release with no input -> all outputs unchanged.
- Single path: input 1 sends dat = 4'hA to adr 2 -> in_ack[1] = 1 in the same cycle; next cycle out_valid[2] = 1, out_dat[2] = 4'hA, out_cnt[2] = 1. Pulse out_ack[2] -> out_valid[2] = 0.
- Round-robin contention: inputs 0..3 continuously target output 0 (data = port index), out_ack[0] held high, rr_0 = 0 -> output 0 delivers 0,1,2,3,0,1,... and each in_ack rises once per 4 cycles.
- Full/back-pressure: input 0 sends 6 words (1..6) to output 3 with out_ack[3] = 0 -> words 1..4 acked, out_cnt[3] = 4, in_ack[0] stays 0. Pop one -> word 5 is acked the cycle after the pop, never the same cycle. Drain order is 1..5.
- Bad address: input 2 sends adr = 5 with NPORT = 4 -> in_ack[2] = 1, no output changes, drop_cnt = 1. Four inputs bad in one cycle -> drop_cnt += 4. With CW = 2, drop_cnt saturates at 3.
- Mid-operation reset: FIFOs at out_cnt = 3, assert rst_i for 1 cycle -> next cycle all out_cnt = 0, out_valid = 0, rr pointers 0. A subsequent single transfer behaves as in the single-path test.

Source files
------------

// File: rtl/switch_xbar_if.sv
// Crossbar bus bundle: X-side word inputs with valid/ack, Y-side FIFO outputs
// with valid/ack, plus fill levels and the bad-address drop counter.
interface switch_xbar_if #(
  parameter int NPORT = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 2,
  parameter int AW    = 3,
  parameter int CW    = 8
);
  logic [NPORT-1:0]           in_valid;
  logic [NPORT*AW-1:0]        in_adr;
  logic [NPORT*DW-1:0]        in_dat;
  logic [NPORT-1:0]           in_ack;
  logic [NPORT-1:0]           out_valid;
  logic [NPORT*DW-1:0]        out_dat;
  logic [NPORT-1:0]           out_ack;
  logic [NPORT*(DEPTH+1)-1:0] out_cnt;
  logic [CW-1:0]              drop_cnt;

  modport master (
    output in_valid, in_adr, in_dat, out_ack,
    input  in_ack, out_valid, out_dat, out_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_adr, in_dat, out_ack,
    output in_ack, out_valid, out_dat, out_cnt, drop_cnt
  );
endinterface

// File: rtl/switch_xbar.sv
// N-port packet-word crossbar: per-output round-robin arbiter feeding a
// show-ahead FIFO; out-of-range destinations are accepted, discarded and counted.
module switch_xbar #(
  parameter int NPORT = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 2,
  parameter int AW    = 3,
  parameter int CW    = 8
) (
  input logic        clk_i,
  input logic        rst_i,
  switch_xbar_if.slave bus
);
  localparam int ENT = 1 << DEPTH;
  localparam int RRW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int SW  = CW + 6;

  logic [DW-1:0]    mem_q [NPORT][ENT];
  logic [DW-1:0]    mem_d [NPORT][ENT];
  logic [DEPTH-1:0] wp_q [NPORT];
  logic [DEPTH-1:0] wp_d [NPORT];
  logic [DEPTH-1:0] rp_q [NPORT];
  logic [DEPTH-1:0] rp_d [NPORT];
  logic [DEPTH:0]   cnt_q [NPORT];
  logic [DEPTH:0]   cnt_d [NPORT];
  logic [RRW-1:0]   rr_q [NPORT];
  logic [RRW-1:0]   rr_d [NPORT];
  logic [CW-1:0]    drop_q, drop_d;

  logic [NPORT-1:0] bad;
  logic [NPORT-1:0] gnt_vld;
  logic [RRW-1:0]   gnt_idx [NPORT];
  logic [NPORT-1:0] in_ack_c;

  // Address decode and round-robin arbitration; fullness uses registered count only
  always_comb begin
    int  idx;
    logic full_j;
    bad      = '0;
    gnt_vld  = '0;
    in_ack_c = '0;
    idx      = 0;
    full_j   = 1'b0;
    for (int j = 0; j < NPORT; j++) gnt_idx[j] = '0;
    for (int i = 0; i < NPORT; i++)
      bad[i] = bus.in_valid[i] && (int'(bus.in_adr[i*AW +: AW]) >= NPORT);
    for (int j = 0; j < NPORT; j++) begin
      full_j = (cnt_q[j] == (DEPTH+1)'(ENT));
      for (int k = 0; k < NPORT; k++) begin
        idx = (int'(rr_q[j]) + k) % NPORT;
        if (!gnt_vld[j] && !full_j && bus.in_valid[idx] &&
            (int'(bus.in_adr[idx*AW +: AW]) == j)) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = RRW'(idx);
        end
      end
    end
    for (int j = 0; j < NPORT; j++)
      if (gnt_vld[j]) in_ack_c[gnt_idx[j]] = 1'b1;
    in_ack_c = in_ack_c | bad;
    if (rst_i) in_ack_c = '0;
  end

  // Next FIFO contents, pointers, fill levels, rr pointers and drop count
  always_comb begin
    logic          pop_j;
    logic [SW-1:0] drop_sum;
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    pop_j    = 1'b0;
    for (int j = 0; j < NPORT; j++) begin
      pop_j = bus.out_ack[j] && (cnt_q[j] != '0);
      if (gnt_vld[j]) begin
        mem_d[j][wp_q[j]] = bus.in_dat[int'(gnt_idx[j])*DW +: DW];
        wp_d[j] = wp_q[j] + 1'b1;
        rr_d[j] = RRW'((int'(gnt_idx[j]) + 1) % NPORT);
      end
      if (pop_j) rp_d[j] = rp_q[j] + 1'b1;
      cnt_d[j] = cnt_q[j] + (DEPTH+1)'(gnt_vld[j]) - (DEPTH+1)'(pop_j);
    end
    drop_sum = SW'(drop_q) + SW'($countones(bad));
    if (drop_sum > SW'({CW{1'b1}})) drop_d = '1;
    else drop_d = drop_sum[CW-1:0];
  end

  // Control state registers with synchronous flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < NPORT; j++) begin
        wp_q[j]  <= '0;
        rp_q[j]  <= '0;
        cnt_q[j] <= '0;
        rr_q[j]  <= '0;
      end
      drop_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
    end
  end

  // FIFO storage; stale entries are masked by the zero count after reset
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Show-ahead outputs: head word when non-empty, zero otherwise
  always_comb begin
    bus.in_ack    = in_ack_c;
    bus.out_valid = '0;
    bus.out_dat   = '0;
    bus.out_cnt   = '0;
    for (int j = 0; j < NPORT; j++) begin
      bus.out_cnt[j*(DEPTH+1) +: DEPTH+1] = cnt_q[j];
      if (cnt_q[j] != '0) begin
        bus.out_valid[j]          = 1'b1;
        bus.out_dat[j*DW +: DW]   = mem_q[j][rp_q[j]];
      end
    end
    bus.drop_cnt = drop_q;
  end
endmodule

// File: tb/tb_switch_xbar.sv
// Bench for switch_xbar: directed scenarios plus random traffic against a
// queue-based reference model of the crossbar.
module tb_switch_xbar;
  localparam int NPORT = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 3;
  localparam int CW    = 8;
  localparam int ENT   = 1 << DEPTH;
  localparam int CNW   = NPORT*(DEPTH+1);
  localparam int STW   = NPORT + CNW + NPORT*DW + CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  switch_xbar_if #(.NPORT(NPORT), .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) bus ();

  switch_xbar #(.NPORT(NPORT), .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // reference model: one queue per output, rr pointer per output, drop count
  logic [DW-1:0]    mq [NPORT][$];
  int               m_rr [NPORT];
  int               m_drop = 0;
  int               g_src [NPORT];
  logic [NPORT-1:0] m_pop;
  int               m_nbad;
  logic [NPORT-1:0] e_ack;

  function automatic int adr_of(int i);
    return int'(bus.in_adr[i*AW +: AW]);
  endfunction

  function automatic void model_ack();
    int i;
    e_ack  = '0;
    m_pop  = '0;
    m_nbad = 0;
    for (int j = 0; j < NPORT; j++) g_src[j] = -1;
    if (rst) return;
    for (int p = 0; p < NPORT; p++)
      if (bus.in_valid[p] && adr_of(p) >= NPORT) begin
        e_ack[p] = 1'b1;
        m_nbad++;
      end
    for (int j = 0; j < NPORT; j++) begin
      m_pop[j] = bus.out_ack[j] && (mq[j].size() > 0);
      if (mq[j].size() < ENT)
        for (int k = 0; k < NPORT; k++) begin
          i = (m_rr[j] + k) % NPORT;
          if (g_src[j] < 0 && bus.in_valid[i] && adr_of(i) == j) begin
            g_src[j] = i;
            e_ack[i] = 1'b1;
          end
        end
    end
  endfunction

  function automatic void model_commit();
    for (int j = 0; j < NPORT; j++) begin
      if (m_pop[j]) void'(mq[j].pop_front());
      if (g_src[j] >= 0) begin
        mq[j].push_back(bus.in_dat[g_src[j]*DW +: DW]);
        m_rr[j] = (g_src[j] + 1) % NPORT;
      end
    end
    m_drop = m_drop + m_nbad;
    if (m_drop > (1 << CW) - 1) m_drop = (1 << CW) - 1;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < NPORT; j++) begin
      mq[j].delete();
      m_rr[j] = 0;
    end
    m_drop = 0;
  endfunction

  function automatic logic [STW-1:0] exp_state();
    logic [NPORT-1:0]    v = '0;
    logic [CNW-1:0]      c = '0;
    logic [NPORT*DW-1:0] d = '0;
    for (int j = 0; j < NPORT; j++) begin
      c[j*(DEPTH+1) +: DEPTH+1] = (DEPTH+1)'(mq[j].size());
      if (mq[j].size() != 0) begin
        v[j] = 1'b1;
        d[j*DW +: DW] = mq[j][0];
      end
    end
    return {v, c, d, CW'(m_drop)};
  endfunction

  function automatic logic [STW-1:0] dut_state();
    return {bus.out_valid, bus.out_cnt, bus.out_dat, bus.drop_cnt};
  endfunction

  task automatic tick();
    model_ack();
    @(posedge clk);
    if (rst) model_reset();
    else model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = '0;
    bus.in_adr   = '0;
    bus.in_dat   = '0;
    bus.out_ack  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.in_valid = '1;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      ntests++;
      if (bus.in_ack !== '0) begin
        nfail++; $display("FAIL reset_ack: got %b want 0", bus.in_ack);
      end
      ntests++;
      if (dut_state() !== '0) begin
        nfail++; $display("FAIL reset_state: got %h want 0", dut_state());
      end
      tick();
    end
    rst = 1'b0;
    bus.in_valid = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      ntests++;
      if (dut_state() !== '0) begin
        nfail++; $display("FAIL idle_state: got %h want 0", dut_state());
      end
    end
  endtask

  task automatic single_path(string tag);
    bus.in_valid = 4'b0010;
    bus.in_adr[1*AW +: AW] = 3'd2;
    bus.in_dat[1*DW +: DW] = 4'hA;
    #1;
    ntests++;
    if (bus.in_ack !== 4'b0010) begin
      nfail++; $display("FAIL %s_ack: got %b want 0010", tag, bus.in_ack);
    end
    tick();
    bus.in_valid = '0;
    #1;
    ntests++;
    if (bus.out_valid[2] !== 1'b1 || bus.out_dat[2*DW +: DW] !== 4'hA ||
        bus.out_cnt[2*(DEPTH+1) +: DEPTH+1] !== 3'd1) begin
      nfail++;
      $display("FAIL %s_out: got v=%b d=%h c=%0d want v=1 d=a c=1", tag,
               bus.out_valid[2], bus.out_dat[2*DW +: DW], bus.out_cnt[2*(DEPTH+1) +: DEPTH+1]);
    end
    ntests++;
    if (dut_state() !== exp_state()) begin
      nfail++; $display("FAIL %s_state: got %h want %h", tag, dut_state(), exp_state());
    end
    bus.out_ack = 4'b0100;
    tick();
    bus.out_ack = '0;
    #1;
    ntests++;
    if (bus.out_valid !== 4'b0000) begin
      nfail++; $display("FAIL %s_pop: got %b want 0000", tag, bus.out_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    single_path("single");
  endtask

  task automatic test_rr_contention();
    logic [DW-1:0] got [$];
    int            ack_cnt [NPORT];
    int            bad_seq = 0;
    do_reset();
    for (int i = 0; i < NPORT; i++) begin
      ack_cnt[i] = 0;
      bus.in_adr[i*AW +: AW] = '0;
      bus.in_dat[i*DW +: DW] = DW'(i);
    end
    bus.in_valid = '1;
    bus.out_ack  = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      #1;
      model_ack();
      ntests++;
      if (bus.in_ack !== e_ack) begin
        nfail++; $display("FAIL rr_ack cyc %0d: got %b want %b", c, bus.in_ack, e_ack);
      end
      ntests++;
      if (dut_state() !== exp_state()) begin
        nfail++; $display("FAIL rr_state cyc %0d: got %h want %h", c, dut_state(), exp_state());
      end
      for (int i = 0; i < NPORT; i++) ack_cnt[i] += int'(bus.in_ack[i]);
      if (bus.out_valid[0] && bus.out_ack[0]) got.push_back(bus.out_dat[DW-1:0]);
      tick();
    end
    for (int k = 0; k < 12; k++)
      if (k >= got.size() || got[k] !== DW'(k % NPORT)) bad_seq++;
    ntests++;
    if (bad_seq != 0) begin
      nfail++; $display("FAIL rr_order: got %0d wrong of 12 delivered, want 0", bad_seq);
    end
    for (int i = 0; i < NPORT; i++) begin
      ntests++;
      if (ack_cnt[i] != 4) begin
        nfail++; $display("FAIL rr_ackrate in%0d: got %0d acks want 4", i, ack_cnt[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [DW-1:0] popped [$];
    int            w = 1;
    int            bad_seq = 0;
    do_reset();
    bus.in_valid = 4'b0001;
    bus.in_adr[0 +: AW] = 3'd3;
    bus.in_dat[0 +: DW] = DW'(w);
    for (int c = 0; c < 8; c++) begin
      #1;
      model_ack();
      ntests++;
      if (bus.in_ack !== e_ack) begin
        nfail++; $display("FAIL full_ack cyc %0d: got %b want %b", c, bus.in_ack, e_ack);
      end
      tick();
      if (e_ack[0]) w++;
      bus.in_dat[0 +: DW] = DW'(w);
    end
    #1;
    ntests++;
    if (bus.out_cnt[3*(DEPTH+1) +: DEPTH+1] !== 3'd4 || bus.in_ack[0] !== 1'b0) begin
      nfail++;
      $display("FAIL full_hold: got cnt=%0d ack=%b want cnt=4 ack=0",
               bus.out_cnt[3*(DEPTH+1) +: DEPTH+1], bus.in_ack[0]);
    end
    bus.out_ack = 4'b1000;
    #1;
    ntests++;
    if (bus.in_ack[0] !== 1'b0) begin
      nfail++; $display("FAIL full_samecyc: got ack=%b want 0", bus.in_ack[0]);
    end
    if (bus.out_valid[3]) popped.push_back(bus.out_dat[3*DW +: DW]);
    tick();
    bus.out_ack = '0;
    #1;
    ntests++;
    if (bus.in_ack[0] !== 1'b1 || bus.in_dat[0 +: DW] !== 4'd5) begin
      nfail++; $display("FAIL full_nextcyc: got ack=%b want 1 for word 5", bus.in_ack[0]);
    end
    tick();
    bus.in_valid = '0;
    bus.out_ack  = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      #1;
      ntests++;
      if (dut_state() !== exp_state()) begin
        nfail++; $display("FAIL drain_state cyc %0d: got %h want %h", c, dut_state(), exp_state());
      end
      if (bus.out_valid[3]) popped.push_back(bus.out_dat[3*DW +: DW]);
      tick();
    end
    for (int k = 0; k < 5; k++)
      if (k >= popped.size() || popped[k] !== DW'(k + 1)) bad_seq++;
    ntests++;
    if (bad_seq != 0 || popped.size() != 5) begin
      nfail++; $display("FAIL full_order: got %0d wrong, %0d words, want 0 wrong 5 words", bad_seq, popped.size());
    end
    idle_inputs();
  endtask

  task automatic test_bad_addr();
    do_reset();
    bus.in_valid = 4'b0100;
    bus.in_adr[2*AW +: AW] = 3'd5;
    bus.in_dat[2*DW +: DW] = 4'h7;
    #1;
    ntests++;
    if (bus.in_ack !== 4'b0100) begin
      nfail++; $display("FAIL bad_ack: got %b want 0100", bus.in_ack);
    end
    tick();
    bus.in_valid = '0;
    #1;
    ntests++;
    if (bus.drop_cnt !== 8'd1 || bus.out_valid !== '0 || bus.out_cnt !== '0) begin
      nfail++; $display("FAIL bad_one: got drop=%0d v=%b want drop=1 v=0", bus.drop_cnt, bus.out_valid);
    end
    for (int i = 0; i < NPORT; i++) bus.in_adr[i*AW +: AW] = AW'(4 + i);
    bus.in_valid = '1;
    #1;
    ntests++;
    if (bus.in_ack !== 4'b1111) begin
      nfail++; $display("FAIL bad_four_ack: got %b want 1111", bus.in_ack);
    end
    tick();
    bus.in_valid = '0;
    #1;
    ntests++;
    if (bus.drop_cnt !== 8'd5) begin
      nfail++; $display("FAIL bad_four: got %0d want 5", bus.drop_cnt);
    end
    bus.in_valid = '1;
    for (int c = 0; c < 70; c++) begin
      tick();
      ntests++;
      if (dut_state() !== exp_state()) begin
        nfail++; $display("FAIL bad_sat_state cyc %0d: got %h want %h", c, dut_state(), exp_state());
      end
    end
    ntests++;
    if (bus.drop_cnt !== 8'd255) begin
      nfail++; $display("FAIL bad_saturate: got %0d want 255", bus.drop_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < NPORT; i++) begin
      bus.in_adr[i*AW +: AW] = AW'(i);
      bus.in_dat[i*DW +: DW] = DW'($urandom);
    end
    bus.in_valid = '1;
    for (int c = 0; c < 3; c++) tick();
    bus.in_valid = '0;
    #1;
    ntests++;
    if (bus.out_cnt !== 12'b011_011_011_011) begin
      nfail++; $display("FAIL midrst_fill: got %b want 011011011011", bus.out_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    ntests++;
    if (bus.out_cnt !== '0 || bus.out_valid !== '0 || bus.out_dat !== '0) begin
      nfail++; $display("FAIL midrst_clear: got cnt=%b v=%b want 0", bus.out_cnt, bus.out_valid);
    end
    idle_inputs();
    single_path("midrst");
  endtask

  task automatic test_random();
    logic [NPORT-1:0] last_ack;
    do_reset();
    last_ack = '1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NPORT; i++)
        if (!bus.in_valid[i] || last_ack[i]) begin
          bus.in_valid[i] = ($urandom_range(0, 3) != 0);
          bus.in_adr[i*AW +: AW] = ($urandom_range(0, 9) < 8) ?
                                   AW'($urandom_range(0, NPORT-1)) : AW'($urandom_range(NPORT, 7));
          bus.in_dat[i*DW +: DW] = DW'($urandom);
        end
      bus.out_ack = NPORT'($urandom);
      #1;
      model_ack();
      ntests++;
      if (bus.in_ack !== e_ack) begin
        nfail++; $display("FAIL rand_ack cyc %0d: got %b want %b", c, bus.in_ack, e_ack);
      end
      ntests++;
      if (dut_state() !== exp_state()) begin
        nfail++; $display("FAIL rand_state cyc %0d: got %h want %h", c, dut_state(), exp_state());
      end
      last_ack = e_ack;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_contention();
    test_full();
    test_bad_addr();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
